// File: rtl/av_pkt_pkg.sv
// Payload type codes shared with the receiver, scheduler FSM encoding and
// the default aux payload size.
package av_pkt_pkg;

  localparam logic [7:0] VIDEO = 8'h00;
  localparam logic [7:0] AUDIO = 8'h01;
  localparam logic [7:0] VIDAX = 8'h02;

  localparam int AUX_WORDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } sched_state_t;

  // Video packets carry no aux words; audio and vidax carry a full aux block.
  function automatic logic [5:0] aux_words_for(input logic [7:0] ptype, input int aux_words);
    return (ptype == VIDEO) ? 6'd0 : 6'(aux_words);
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with a one-cycle expiry indication, shared by the
// inter-frame gap and the tx_done watchdog.
module sched_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Expiry fires on the last counted cycle, so a load of N spans N enabled cycles.
  assign expire = en && (count == W'(1));

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII-domain transmit scheduler: picks video/audio/vidax packets and paces the
// packet builder. Define SCHED_STATS_EN to add per-type issue counters.
module gmii_tx_sched
  import av_pkt_pkg::*;
#(
  parameter int AUX_WORDS    = AUX_WORDS_DEFAULT,
  parameter int AUX_MAX_WAIT = 1024,
  parameter int IFG_CYCLES   = 12,
  parameter int DONE_TIMEOUT = 4095,
  parameter int LVL_W        = 10
) (
  input  logic             clk125,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             vid_ready,
  input  logic [LVL_W-1:0] aux_level,
  output logic             tx_start,
  output logic [7:0]       tx_type,
  output logic [5:0]       tx_aux_words,
  input  logic             tx_done,
  output logic             sched_idle,
  output logic             tx_timeout
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]      cnt_video,
  output logic [15:0]      cnt_audio,
  output logic [15:0]      cnt_vidax
`endif
);

  localparam int TMR_W = (DONE_TIMEOUT > IFG_CYCLES) ? $clog2(DONE_TIMEOUT + 1)
                                                     : $clog2(IFG_CYCLES + 1);
  localparam logic [LVL_W-1:0] AUX_LVL  = LVL_W'(AUX_WORDS);
  localparam logic [10:0]      WAIT_MAX = 11'(AUX_MAX_WAIT);
  // The ISSUE cycle counts toward the watchdog, hence one less in the load.
  localparam logic [TMR_W-1:0] WD_LOAD  = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(IFG_CYCLES);

  sched_state_t     state;
  logic [10:0]      aux_wait;
  logic             aux_pending;
  logic             decide;
  logic             issue_aux;
  logic [7:0]       next_type;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_expire;
  logic [TMR_W-1:0] tmr_val;

  assign aux_pending = (aux_level >= AUX_LVL);

  always_comb begin
    decide    = 1'b0;
    next_type = VIDEO;
    if ((state == S_IDLE) && enable) begin
      if (vid_ready) begin
        decide    = 1'b1;
        next_type = aux_pending ? VIDAX : VIDEO;
      end else if (aux_pending && (aux_wait == WAIT_MAX)) begin
        decide    = 1'b1;
        next_type = AUDIO;
      end
    end
  end

  assign issue_aux = decide && (next_type != VIDEO);

  // One timer serves both roles: watchdog armed in ISSUE, gap armed on leaving WAIT_DONE.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = GAP_LOAD;
    tmr_en   = (state == S_WAIT_DONE) || (state == S_GAP);
    if (state == S_ISSUE) begin
      tmr_load = 1'b1;
      tmr_val  = WD_LOAD;
    end else if ((state == S_WAIT_DONE) && (tx_done || tmr_expire)) begin
      tmr_load = 1'b1;
      tmr_val  = GAP_LOAD;
    end
  end

  sched_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk125),
    .rst      (sys_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      tx_start     <= 1'b0;
      tx_type      <= VIDEO;
      tx_aux_words <= 6'd0;
      sched_idle   <= 1'b1;
      tx_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (decide) begin
            state        <= S_ISSUE;
            tx_start     <= 1'b1;
            tx_type      <= next_type;
            tx_aux_words <= aux_words_for(next_type, AUX_WORDS);
            sched_idle   <= 1'b0;
          end
        end
        S_ISSUE: begin
          tx_start <= 1'b0;
          state    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            state <= S_GAP;
          end else if (tmr_expire) begin
            tx_timeout <= 1'b1;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (tmr_expire) begin
            state      <= S_IDLE;
            sched_idle <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Starvation timer for audio: only advances while idle and video-starved.
  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      aux_wait <= 11'd0;
    end else if (!aux_pending || issue_aux) begin
      aux_wait <= 11'd0;
    end else if ((state == S_IDLE) && enable && !vid_ready && (aux_wait != WAIT_MAX)) begin
      aux_wait <= aux_wait + 11'd1;
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      cnt_video <= 16'd0;
      cnt_audio <= 16'd0;
      cnt_vidax <= 16'd0;
    end else if (tx_start) begin
      case (tx_type)
        VIDEO:   cnt_video <= cnt_video + 16'd1;
        AUDIO:   cnt_audio <= cnt_audio + 16'd1;
        VIDAX:   cnt_vidax <= cnt_vidax + 16'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: decision table, timing corner sequences and
// randomized trials against an event-level model of the scheduling rules.
module tb_gmii_tx_sched;
  import av_pkt_pkg::*;

  localparam int IFG   = 12;
  localparam int DTO   = 4095;
  localparam int MAXW  = 1024;
  localparam int AUXW  = 32;

  logic       clk125 = 1'b0;
  logic       sys_rst, enable, vid_ready, tx_done;
  logic [9:0] aux_level;
  logic       tx_start, sched_idle, tx_timeout;
  logic [7:0] tx_type;
  logic [5:0] tx_aux_words;
`ifdef SCHED_STATS_EN
  logic [15:0] cnt_video, cnt_audio, cnt_vidax;
`endif

  int checks = 0;
  int failures = 0;

  gmii_tx_sched dut (
    .clk125       (clk125),
    .sys_rst      (sys_rst),
    .enable       (enable),
    .vid_ready    (vid_ready),
    .aux_level    (aux_level),
    .tx_start     (tx_start),
    .tx_type      (tx_type),
    .tx_aux_words (tx_aux_words),
    .tx_done      (tx_done),
    .sched_idle   (sched_idle),
    .tx_timeout   (tx_timeout)
`ifdef SCHED_STATS_EN
    ,
    .cnt_video    (cnt_video),
    .cnt_audio    (cnt_audio),
    .cnt_vidax    (cnt_vidax)
`endif
  );

  always #4 clk125 = ~clk125;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic neutral();
    vid_ready = 1'b0;
    aux_level = 10'd0;
  endtask

  // Ticks until tx_start is seen; n = ticks taken, or -1 if the budget ran out.
  task automatic wait_start(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called in the tx_start cycle: done after d ticks, then ticks until idle.
  task automatic finish_pkt(input int d, output int idle_lat);
    for (int i = 0; i < d; i++) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    idle_lat = 1;
    while (sched_idle !== 1'b1 && idle_lat < 100) begin
      tick();
      idle_lat++;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  typedef struct {
    bit         en;
    bit         vid;
    int         lvl;
    bit         exp_start;
    logic [7:0] exp_type;
    logic [5:0] exp_words;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, lat, v, a, q, d, exp_n;
    logic [7:0] exp_type;
    logic [5:0] exp_words;

    vecs[0] = '{1, 1,    0, 1, VIDEO, 6'd0};
    vecs[1] = '{1, 1,   40, 1, VIDAX, 6'd32};
    vecs[2] = '{1, 1,   31, 1, VIDEO, 6'd0};
    vecs[3] = '{1, 1,   32, 1, VIDAX, 6'd32};
    vecs[4] = '{1, 0,  500, 0, VIDEO, 6'd0};
    vecs[5] = '{1, 0,    0, 0, VIDEO, 6'd0};
    vecs[6] = '{0, 1,   40, 0, VIDEO, 6'd0};
    vecs[7] = '{1, 1, 1023, 1, VIDAX, 6'd32};
    vecs[8] = '{0, 0,   40, 0, VIDEO, 6'd0};

    sys_rst = 1'b1; enable = 1'b0; tx_done = 1'b0;
    neutral();
    tick(); tick(); tick();
    check("rst_start", tx_start, 0);
    check("rst_type", tx_type, 0);
    check("rst_words", tx_aux_words, 0);
    check("rst_idle", sched_idle, 1);
    check("rst_timeout", tx_timeout, 0);
    sys_rst = 1'b0;
    tick();

    // Decision table: one registered decision cycle from IDLE.
    for (int i = 0; i < 9; i++) begin
      enable    = vecs[i].en;
      vid_ready = vecs[i].vid;
      aux_level = 10'(vecs[i].lvl);
      tick();
      check($sformatf("vec%0d_start", i), tx_start, vecs[i].exp_start);
      if (vecs[i].exp_start) begin
        check($sformatf("vec%0d_type", i), tx_type, vecs[i].exp_type);
        check($sformatf("vec%0d_words", i), tx_aux_words, vecs[i].exp_words);
      end
      neutral();
      if (tx_start === 1'b1) begin
        finish_pkt(3, lat);
        check($sformatf("vec%0d_gap", i), lat, IFG + 1);
      end else begin
        tick();
      end
    end

    // Video only, long packet, video still ready: next start IFG+2 after done.
    enable = 1'b1; vid_ready = 1'b1; aux_level = 10'd0;
    wait_start(5, n);
    check("vid_first_lat", n, 1);
    check("vid_type", tx_type, VIDEO);
    for (int i = 0; i < 1300; i++) tick();
    tx_done = 1'b1;
    wait_start(1, n);
    tx_done = 1'b0;
    if (n < 0) begin
      wait_start(40, n);
      if (n > 0) n++;
    end
    check("vid_ifg_restart", n, IFG + 2);
    neutral();
    finish_pkt(2, lat);

    // Audio starvation: forced after the full wait.
    vid_ready = 1'b0; aux_level = 10'd32;
    wait_start(1100, n);
    check("audio_lat", n, MAXW + 1);
    check("audio_type", tx_type, AUDIO);
    check("audio_words", tx_aux_words, AUXW);
    neutral();
    finish_pkt(4, lat);
    check("audio_gap", lat, IFG + 1);

    // Aux dips below threshold at cycle 500: wait restarts.
    aux_level = 10'd32;
    wait_start(500, n);
    check("dip_no_early", n, -1);
    aux_level = 10'd31;
    tick();
    aux_level = 10'd32;
    wait_start(1200, n);
    check("dip_restart_lat", n, MAXW + 1);
    neutral();
    if (n > 0) finish_pkt(2, lat);

    // tx_done in the ISSUE cycle must be ignored.
    vid_ready = 1'b1;
    wait_start(5, n);
    neutral();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("issue_done_ignored", sched_idle, 0);
    finish_pkt(1, lat);
    check("issue_done_gap", lat, IFG + 1);

    // Watchdog: no tx_done at all.
    vid_ready = 1'b1;
    wait_start(5, n);
    neutral();
    for (int i = 0; i < DTO - 1; i++) tick();
    check("wd_before", tx_timeout, 0);
    tick();
    check("wd_fire", tx_timeout, 1);
    check("wd_busy", sched_idle, 0);
    for (int i = 0; i < IFG; i++) tick();
    check("wd_idle", sched_idle, 1);
    vid_ready = 1'b1;
    wait_start(5, n);
    neutral();
    finish_pkt(2, lat);
    check("wd_sticky", tx_timeout, 1);

    // sys_rst in WAIT_DONE.
    vid_ready = 1'b1; aux_level = 10'd40;
    wait_start(5, n);
    neutral();
    for (int i = 0; i < 5; i++) tick();
    sys_rst = 1'b1;
    tick();
    check("mrst_start", tx_start, 0);
    check("mrst_type", tx_type, 0);
    check("mrst_words", tx_aux_words, 0);
    check("mrst_idle", sched_idle, 1);
    check("mrst_timeout", tx_timeout, 0);
    sys_rst = 1'b0;
    vid_ready = 1'b1;
    wait_start(5, n);
    check("mrst_recover", n, 1);
    neutral();
    finish_pkt(2, lat);

    // enable dropped in WAIT_DONE: packet completes, nothing new until re-enabled.
    vid_ready = 1'b1;
    wait_start(5, n);
    tick(); tick(); tick();
    enable = 1'b0;
    finish_pkt(7, lat);
    check("en_drop_gap", lat, IFG + 1);
    wait_start(50, n);
    check("en_drop_quiet", n, -1);
    enable = 1'b1;
    wait_start(3, n);
    check("en_restore", n, 1);
    neutral();
    finish_pkt(2, lat);

    // Randomized trials against the rule-level model.
    for (int t = 0; t < 14; t++) begin
      v = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(32, 1023)) : int'($urandom_range(0, 31));
      q = int'($urandom_range(0, 4));
      d = int'($urandom_range(1, 40));
      exp_n = -1; exp_type = VIDEO; exp_words = 6'd0;
      if (v != 0) begin
        exp_n = 1;
        exp_type  = (a >= AUXW) ? VIDAX : VIDEO;
        exp_words = (a >= AUXW) ? 6'(AUXW) : 6'd0;
      end else if (a >= AUXW) begin
        exp_n = MAXW + 1;
        exp_type = AUDIO; exp_words = 6'(AUXW);
      end
      enable = 1'b0; vid_ready = v[0]; aux_level = 10'(a);
      for (int i = 0; i < q; i++) begin
        tick();
        check($sformatf("rnd%0d_gated", t), tx_start, 0);
      end
      enable = 1'b1;
      wait_start((exp_n < 0) ? 40 : exp_n + 5, n);
      check($sformatf("rnd%0d_lat", t), n, exp_n);
      neutral();
      if (n > 0) begin
        if (exp_n > 0) begin
          check($sformatf("rnd%0d_type", t), tx_type, exp_type);
          check($sformatf("rnd%0d_words", t), tx_aux_words, exp_words);
        end
        finish_pkt(d, lat);
        check($sformatf("rnd%0d_gap", t), lat, IFG + 1);
        if (exp_n > 0) check($sformatf("rnd%0d_hold", t), tx_type, exp_type);
      end else begin
        tick();
      end
    end

`ifdef SCHED_STATS_EN
    do_reset();
    check("stat_rst_video", cnt_video, 0);
    for (int i = 0; i < 5; i++) begin
      vid_ready = 1'b1;
      aux_level = (i < 3) ? 10'd0 : 10'd40;
      wait_start(5, n);
      neutral();
      finish_pkt(2, lat);
    end
    check("stat_video", cnt_video, 3);
    check("stat_vidax", cnt_vidax, 2);
    check("stat_audio", cnt_audio, 0);
`else
    do_reset();
`endif
    check("final_idle", sched_idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
